// File: rtl/qch_device_responder.sv
// Device-side Q-Channel responder: synchronises QREQn, drives a datapath flush and
// accepts only when quiescent. Optional denial path built when QCH_DENY_EN is defined.
module qch_device_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int EXIT_DELAY  = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic qreqn_i,
  output logic qacceptn_o,
  output logic qdeny_o,
  output logic qactive_o,
  input  logic busy_i,
  input  logic wakeup_i,
  output logic flush_req_o,
  input  logic flush_done_i,
  output logic stopped_o,
  output logic proto_err_o
);

  localparam int EXIT_W = $clog2(EXIT_DELAY + 1);

  if (SYNC_STAGES < 2 || EXIT_DELAY < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("qch_device_responder: parameter out of range");
  end

  typedef enum logic [2:0] {
    Q_RUN      = 3'd0,
    Q_REQUEST  = 3'd1,
    Q_STOPPED  = 3'd2,
    Q_EXIT     = 3'd3,
    Q_DENIED   = 3'd4,
    Q_CONTINUE = 3'd5
  } state_t;

  state_t                   state_reg;
  logic [SYNC_STAGES-1:0]   sync_reg;
  logic [EXIT_W-1:0]        exit_cnt_reg;
  logic                     qreqn_s;
  logic                     accept_ok;

  // Preset to 1 so a reset never looks like a fresh request until the pin is resampled.
  always_ff @(posedge clk) begin
    if (reset) sync_reg <= '1;
    else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], qreqn_i};
  end

  assign qreqn_s   = sync_reg[SYNC_STAGES-1];
  assign accept_ok = flush_done_i & ~busy_i & ~wakeup_i;

`ifdef QCH_DENY_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_reg;
`else
  assign qdeny_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= Q_RUN;
      qacceptn_o   <= 1'b1;
      qactive_o    <= 1'b0;
      flush_req_o  <= 1'b0;
      stopped_o    <= 1'b0;
      proto_err_o  <= 1'b0;
      exit_cnt_reg <= '0;
`ifdef QCH_DENY_EN
      qdeny_o      <= 1'b0;
      cnt_reg      <= '0;
`endif
    end else begin
      proto_err_o <= 1'b0;
      qactive_o   <= busy_i | wakeup_i | flush_req_o;
      case (state_reg)
        Q_RUN: begin
          if (!qreqn_s) begin
            state_reg   <= Q_REQUEST;
            flush_req_o <= 1'b1;
`ifdef QCH_DENY_EN
            cnt_reg     <= '0;
`endif
          end
        end
        Q_REQUEST: begin
          // Priority: early QREQn release, then accept, then denial.
          if (qreqn_s) begin
            state_reg   <= Q_RUN;
            flush_req_o <= 1'b0;
            proto_err_o <= 1'b1;
          end else if (accept_ok) begin
            state_reg   <= Q_STOPPED;
            qacceptn_o  <= 1'b0;
            flush_req_o <= 1'b0;
            stopped_o   <= 1'b1;
`ifdef QCH_DENY_EN
          end else if (wakeup_i || cnt_reg == CNT_W'(TIMEOUT)) begin
            state_reg   <= Q_DENIED;
            qdeny_o     <= 1'b1;
            flush_req_o <= 1'b0;
          end else begin
            cnt_reg     <= cnt_reg + 1'b1;
`endif
          end
        end
        Q_STOPPED: begin
          if (qreqn_s) begin
            state_reg    <= Q_EXIT;
            stopped_o    <= 1'b0;
            exit_cnt_reg <= '0;
          end
        end
        Q_EXIT: begin
          if (exit_cnt_reg == EXIT_W'(EXIT_DELAY - 1)) begin
            state_reg  <= Q_RUN;
            qacceptn_o <= 1'b1;
          end else begin
            exit_cnt_reg <= exit_cnt_reg + 1'b1;
          end
        end
`ifdef QCH_DENY_EN
        Q_DENIED: begin
          if (qreqn_s) state_reg <= Q_CONTINUE;
        end
        Q_CONTINUE: begin
          state_reg <= Q_RUN;
          qdeny_o   <= 1'b0;
        end
`endif
        default: state_reg <= Q_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_qch_device_responder.sv
// Bench for qch_device_responder: directed vector table, hand sequences for the
// corner cases, and a random run checked against a timing-rule reference model.
module tb_qch_device_responder;
  localparam int S  = 2;
  localparam int TO = 8;
  localparam int ED = 2;
`ifdef QCH_DENY_EN
  localparam bit DENY = 1'b1;
`else
  localparam bit DENY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, qreqn_i, busy_i, wakeup_i, flush_done_i;
  logic qacceptn_o, qdeny_o, qactive_o, flush_req_o, stopped_o, proto_err_o;
  int checks = 0;
  int failures = 0;

  qch_device_responder #(.SYNC_STAGES(S), .TIMEOUT(TO), .EXIT_DELAY(ED)) dut (
    .clk(clk), .reset(reset), .qreqn_i(qreqn_i), .qacceptn_o(qacceptn_o),
    .qdeny_o(qdeny_o), .qactive_o(qactive_o), .busy_i(busy_i), .wakeup_i(wakeup_i),
    .flush_req_o(flush_req_o), .flush_done_i(flush_done_i), .stopped_o(stopped_o),
    .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  // Reference model: phases with start timestamps; synchroniser as a delay queue.
  typedef enum {M_RUN, M_REQ, M_STOP, M_EXIT, M_DENY, M_CONT} mode_t;
  mode_t m;
  int    n, t_req, t_exit;
  bit    hist[$];
  bit    m_acc, m_deny, m_act, m_flush, m_stop, m_perr;

  task automatic model_edge(input bit rst, input bit q, input bit b, input bit w, input bit f);
    bit qs, act_n;
    n++;
    if (rst) begin
      m = M_RUN; m_acc = 1; m_deny = 0; m_act = 0; m_flush = 0; m_stop = 0; m_perr = 0;
      hist = {};
      for (int i = 0; i < S; i++) hist.push_back(1'b1);
    end else begin
      qs = hist.pop_front();
      hist.push_back(q);
      act_n = b | w | m_flush;
      m_perr = 0;
      case (m)
        M_RUN:  if (!qs) begin m = M_REQ; m_flush = 1; t_req = n; end
        M_REQ: begin
          if (qs) begin m = M_RUN; m_flush = 0; m_perr = 1; end
          else if (f && !b && !w) begin m = M_STOP; m_acc = 0; m_flush = 0; m_stop = 1; end
          else if (DENY && (w || (n - t_req - 1) >= TO)) begin m = M_DENY; m_deny = 1; m_flush = 0; end
        end
        M_STOP: if (qs) begin m = M_EXIT; m_stop = 0; t_exit = n; end
        M_EXIT: if (n - t_exit == ED) begin m = M_RUN; m_acc = 1; end
        M_DENY: if (qs) m = M_CONT;
        M_CONT: begin m = M_RUN; m_deny = 0; end
        default: m = M_RUN;
      endcase
      m_act = act_n;
    end
  endtask

  function automatic logic [5:0] dut_out();
    return {qacceptn_o, qdeny_o, qactive_o, flush_req_o, stopped_o, proto_err_o};
  endfunction

  task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, sample after the edge, compare to model.
  task automatic cyc(input bit rst, input bit q, input bit b, input bit w, input bit f);
    reset = rst; qreqn_i = q; busy_i = b; wakeup_i = w; flush_done_i = f;
    model_edge(rst, q, b, w, f);
    @(posedge clk); #1;
    chk("model", dut_out(), {m_acc, m_deny, m_act, m_flush, m_stop, m_perr});
  endtask

  task automatic go_request();
    for (int i = 0; i < 10 && !flush_req_o; i++) cyc(0, 0, 0, 0, 0);
    chk("req_entry", 6'(flush_req_o), 6'd1);
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(0, 1, 0, 0, 0);
  endtask

  typedef struct {
    bit       rst, q, b, w, f;
    bit [5:0] exp;  // {acc, deny, act, flush, stop, perr}
  } vec_t;
  vec_t tbl[22];

  initial begin
    // Accept/exit handshake, then busy-blocked request ended by an early QREQn release.
    tbl[0]  = '{1, 1, 0, 0, 0, 6'b100000};
    tbl[1]  = '{0, 0, 0, 0, 0, 6'b100000};
    tbl[2]  = '{0, 0, 0, 0, 0, 6'b100000};
    tbl[3]  = '{0, 0, 0, 0, 0, 6'b100100};
    tbl[4]  = '{0, 0, 0, 0, 0, 6'b101100};
    tbl[5]  = '{0, 0, 0, 0, 0, 6'b101100};
    tbl[6]  = '{0, 0, 0, 0, 0, 6'b101100};
    tbl[7]  = '{0, 0, 0, 0, 1, 6'b001010};
    tbl[8]  = '{0, 0, 0, 0, 1, 6'b000010};
    tbl[9]  = '{0, 1, 0, 0, 0, 6'b000010};
    tbl[10] = '{0, 1, 0, 0, 0, 6'b000010};
    tbl[11] = '{0, 1, 0, 0, 0, 6'b000000};
    tbl[12] = '{0, 1, 0, 0, 0, 6'b000000};
    tbl[13] = '{0, 1, 0, 0, 0, 6'b100000};
    tbl[14] = '{0, 1, 0, 0, 0, 6'b100000};
    tbl[15] = '{0, 0, 1, 0, 0, 6'b101000};
    tbl[16] = '{0, 0, 1, 0, 0, 6'b101000};
    tbl[17] = '{0, 0, 1, 0, 0, 6'b101100};
    tbl[18] = '{0, 1, 1, 0, 1, 6'b101100};
    tbl[19] = '{0, 1, 1, 0, 1, 6'b101100};
    tbl[20] = '{0, 1, 0, 0, 1, 6'b101001};
    tbl[21] = '{0, 1, 0, 0, 0, 6'b100000};

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].rst, tbl[i].q, tbl[i].b, tbl[i].w, tbl[i].f);
      chk($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
    end

    // Reset while stopped with QREQn still low; request must restart S+1 cycles later.
    go_request();
    cyc(0, 0, 0, 0, 1);
    chk("t6_stopped", 6'(stopped_o), 6'd1);
    cyc(1, 0, 0, 0, 0);
    chk("t6_rst", {qacceptn_o, stopped_o, flush_req_o}, 3'b100);
    for (int k = 1; k <= S + 1; k++) begin
      cyc(0, 0, 0, 0, 0);
      chk($sformatf("t6_flush_c%0d", k), 6'(flush_req_o), 6'(k == S + 1));
    end
    cyc(0, 0, 0, 0, 1);
    idle(8);

    // Flush completes on the very cycle the counter reaches TIMEOUT: accept wins.
    go_request();
    repeat (TO) cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t4_acc_deny", {qacceptn_o, qdeny_o}, 2'b00);
    idle(8);

    // Flush never completes.
    go_request();
    repeat (TO + 1) cyc(0, 0, 0, 0, 0);
`ifdef QCH_DENY_EN
    chk("t2_deny", {qacceptn_o, qdeny_o}, 2'b11);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("t2_continue", 6'(qdeny_o), 6'd1);
    cyc(0, 1, 0, 0, 0);
    chk("t2_release", {qacceptn_o, qdeny_o}, 2'b10);
`else
    chk("t2_nodeny", {qacceptn_o, qdeny_o}, 2'b10);
    cyc(0, 0, 0, 0, 1);
    chk("t2_late_acc", 6'(qacceptn_o), 6'd0);
`endif
    idle(8);

    // Wakeup arrives with flush already done.
    go_request();
    cyc(0, 0, 0, 1, 1);
`ifdef QCH_DENY_EN
    chk("t3_deny", {qacceptn_o, qdeny_o, qactive_o}, 3'b111);
`else
    chk("t3_nodeny", {qacceptn_o, qdeny_o, qactive_o}, 3'b101);
    cyc(0, 0, 0, 0, 1);
    chk("t3_acc", 6'(qacceptn_o), 6'd0);
`endif
    idle(8);

    // Random traffic against the model.
    begin
      bit q = 1'b1;
      int hold = 0;
      for (int i = 0; i < 3000; i++) begin
        if (hold == 0) begin
          q = ~q;
          hold = $urandom_range(1, 20);
        end
        hold--;
        cyc($urandom_range(0, 299) == 0, q, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
